trap_ctrl: RTL and testbench

- Trap/return sequencer on the far side of the CSR file's trap and xret update interface.
- Takes synchronous exceptions and MRET requests from execute, and arbitrates enabled pending interrupts.
- Drives trap_do_update/xret_do_update into the CSR file, then issues a fetch redirect and pipeline flush.
- Sits between the execute stage, the CSR file and fetch; machine mode only.

---
 rtl/trap_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer: accepts exceptions, MRET and interrupts, commits CSR updates, then flushes and redirects fetch.
// Optional TRAP_CTRL_VECTORED_EN: vectored interrupt targets when mtvec[1:0]==2'b01.
module trap_ctrl #(
  parameter int XLEN              = 64,
  parameter int ALEN              = 64,
  parameter int PLATFORM_INTR_LEN = 16,
  parameter int INTR_LEN          = 16 + PLATFORM_INTR_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exc_valid,
  input  logic [3:0]          exc_cause,
  input  logic [ALEN-1:0]     exc_pc,
  input  logic [XLEN-1:0]     exc_tval,
  input  logic                mret_valid,
  input  logic                int_boundary,
  output logic                req_ready,
  input  logic [ALEN-1:0]     int_pc,
  input  logic [XLEN-1:0]     mstatus,
  input  logic [INTR_LEN-1:0] mie,
  input  logic [INTR_LEN-1:0] mip,
  input  logic [XLEN-1:0]     mtvec,
  input  logic [ALEN-1:0]     mepc,
  input  logic [1:0]          privilege_mode,
  output logic                trap_do_update,
  output logic [XLEN-1:0]     trap_mcause,
  output logic [ALEN-1:0]     trap_mepc,
  output logic [XLEN-1:0]     trap_mtval,
  output logic                xret_do_update,
  output logic                xret_completing,
  output logic [XLEN-1:0]     xret_new_mstatus,
  output logic [1:0]          xret_new_privilege_mode,
  output logic                flush,
  output logic                redirect_valid,
  output logic [ALEN-1:0]     redirect_pc
);

  localparam int CW = $clog2(INTR_LEN);

  typedef enum logic [1:0] {IDLE, TRAP, XRET, REDIRECT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [ALEN-1:0] mepc_q, mepc_d;
  logic [ALEN-1:0] target_q, target_d;
  logic            xret_ret_q, xret_ret_d;
  logic            xret_comp_q, xret_comp_d;

  logic [INTR_LEN-1:0] pend;
  logic                int_pend;
  logic [CW-1:0]       int_code;
  logic [XLEN-1:0]     int_mcause;
  logic [XLEN-1:0]     mret_mstatus;
  logic [ALEN-1:0]     base;
  logic [ALEN-1:0]     trap_target;
  logic                unused_ok;

  assign pend     = mie & mip;
  assign int_pend = mstatus[3] && (|pend);
  assign base     = {mtvec[ALEN-1:2], 2'b00};
  assign unused_ok = ^{privilege_mode, mtvec};

  // Later assignments win: stray low bits < platform lines < MTI < MSI < MEI.
  always_comb begin
    int_code = '0;
    for (int i = 15; i >= 0; i--) begin
      if (pend[i]) int_code = CW'(i);
    end
    for (int i = INTR_LEN - 1; i >= 16; i--) begin
      if (pend[i]) int_code = CW'(i);
    end
    if (pend[7])  int_code = CW'(7);
    if (pend[3])  int_code = CW'(3);
    if (pend[11]) int_code = CW'(11);
  end

  always_comb begin
    int_mcause               = '0;
    int_mcause[XLEN-1]       = 1'b1;
    int_mcause[CW-1:0]       = int_code;
  end

  always_comb begin
    mret_mstatus        = mstatus;
    mret_mstatus[3]     = mstatus[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b11;
  end

`ifdef TRAP_CTRL_VECTORED_EN
  assign trap_target = (mtvec[1:0] == 2'b01 && mcause_q[XLEN-1])
                     ? base + (ALEN'(mcause_q[CW-1:0]) << 2)
                     : base;
`else
  assign trap_target = base;
`endif

  always_comb begin
    state_d     = state_q;
    mcause_d    = mcause_q;
    mtval_d     = mtval_q;
    mepc_d      = mepc_q;
    target_d    = target_q;
    xret_ret_d  = xret_ret_q;
    xret_comp_d = xret_comp_q;

    req_ready               = 1'b0;
    trap_do_update          = 1'b0;
    trap_mcause             = '0;
    trap_mepc               = '0;
    trap_mtval              = '0;
    xret_do_update          = 1'b0;
    xret_completing         = 1'b0;
    xret_new_mstatus        = '0;
    xret_new_privilege_mode = '0;
    flush                   = 1'b0;
    redirect_valid          = 1'b0;
    redirect_pc             = '0;

    case (state_q)
      IDLE: begin
        req_ready   = 1'b1;
        xret_ret_d  = 1'b0;
        xret_comp_d = 1'b0;
        if (exc_valid) begin
          mcause_d = XLEN'(exc_cause);
          mepc_d   = exc_pc;
          mtval_d  = exc_tval;
          state_d  = TRAP;
        end else if (mret_valid) begin
          state_d  = XRET;
        end else if (int_pend && int_boundary) begin
          mcause_d = int_mcause;
          mepc_d   = int_pc;
          mtval_d  = '0;
          state_d  = TRAP;
        end
      end
      TRAP: begin
        trap_do_update  = 1'b1;
        flush           = 1'b1;
        trap_mcause     = mcause_q;
        trap_mepc       = mepc_q;
        trap_mtval      = mtval_q;
        xret_completing = xret_comp_q;
        target_d        = trap_target;
        xret_ret_d      = 1'b0;
        xret_comp_d     = 1'b0;
        state_d         = REDIRECT;
      end
      XRET: begin
        xret_do_update          = 1'b1;
        flush                   = 1'b1;
        xret_new_mstatus        = mret_mstatus;
        xret_new_privilege_mode = mstatus[12:11];
        target_d                = mepc;
        xret_ret_d              = 1'b1;
        state_d                 = REDIRECT;
      end
      REDIRECT: begin
        // Interrupt unmasked by the MRET itself: trap straight away instead of returning.
        if (xret_ret_q && int_pend) begin
          mcause_d    = int_mcause;
          mepc_d      = int_pc;
          mtval_d     = '0;
          xret_comp_d = 1'b1;
          xret_ret_d  = 1'b0;
          state_d     = TRAP;
        end else begin
          redirect_valid = 1'b1;
          redirect_pc    = target_q;
          xret_ret_d     = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcause_q    <= '0;
      mtval_q     <= '0;
      mepc_q      <= '0;
      target_q    <= '0;
      xret_ret_q  <= 1'b0;
      xret_comp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      mepc_q      <= mepc_d;
      target_q    <= target_d;
      xret_ret_q  <= xret_ret_d;
      xret_comp_q <= xret_comp_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed-vector bench for trap_ctrl (default parameters); vectored expectations follow TRAP_CTRL_VECTORED_EN.
module tb_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [63:0] exc_pc, exc_tval;
  logic        mret_valid, int_boundary, req_ready;
  logic [63:0] int_pc, mstatus;
  logic [31:0] mie, mip;
  logic [63:0] mtvec, mepc;
  logic [1:0]  privilege_mode;
  logic        trap_do_update;
  logic [63:0] trap_mcause, trap_mepc, trap_mtval;
  logic        xret_do_update, xret_completing;
  logic [63:0] xret_new_mstatus;
  logic [1:0]  xret_new_privilege_mode;
  logic        flush, redirect_valid;
  logic [63:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .int_boundary(int_boundary), .req_ready(req_ready),
    .int_pc(int_pc), .mstatus(mstatus), .mie(mie), .mip(mip), .mtvec(mtvec), .mepc(mepc),
    .privilege_mode(privilege_mode),
    .trap_do_update(trap_do_update), .trap_mcause(trap_mcause), .trap_mepc(trap_mepc),
    .trap_mtval(trap_mtval), .xret_do_update(xret_do_update), .xret_completing(xret_completing),
    .xret_new_mstatus(xret_new_mstatus), .xret_new_privilege_mode(xret_new_privilege_mode),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] vec_exp;

  initial begin
`ifdef TRAP_CTRL_VECTORED_EN
    vec_exp = 64'h12C;
`else
    vec_exp = 64'h100;
`endif
    rst = 1'b1; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    mret_valid = 1'b0; int_boundary = 1'b0; int_pc = '0; mstatus = '0;
    mie = '0; mip = '0; mtvec = '0; mepc = '0; privilege_mode = 2'b11;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_trap", 64'(trap_do_update), 64'd0);
    chk("rst_xret", 64'(xret_do_update), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_redir", 64'(redirect_valid), 64'd0);
    chk("rst_rpc", redirect_pc, 64'd0);
    chk("rst_mcause", trap_mcause, 64'd0);

    // Synchronous exception
    mtvec = 64'h8000_0100;
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 64'h1000; exc_tval = 64'hDEAD;
    step();
    exc_valid = 1'b0;
    chk("exc_trap", 64'(trap_do_update), 64'd1);
    chk("exc_flush", 64'(flush), 64'd1);
    chk("exc_mcause", trap_mcause, 64'd2);
    chk("exc_mepc", trap_mepc, 64'h1000);
    chk("exc_mtval", trap_mtval, 64'hDEAD);
    chk("exc_busy", 64'(req_ready), 64'd0);
    chk("exc_noredir", 64'(redirect_valid), 64'd0);
    step();
    chk("exc_redir", 64'(redirect_valid), 64'd1);
    chk("exc_rpc", redirect_pc, 64'h8000_0100);
    chk("exc_trap_off", 64'(trap_do_update), 64'd0);
    step();
    chk("exc_idle", 64'(req_ready), 64'd1);
    chk("exc_redir_off", 64'(redirect_valid), 64'd0);

    // Interrupt masked by mstatus.MIE, then boundary absent
    mie = 32'h888; mip = 32'h888; mstatus = 64'h0; int_boundary = 1'b1; int_pc = 64'h3000;
    step();
    chk("int_masked", 64'(req_ready), 64'd1);
    mstatus = 64'h8; int_boundary = 1'b0;
    step();
    chk("int_noboundary", 64'(req_ready), 64'd1);

    // MEI wins over MSI/MTI
    mtvec = 64'h101; int_boundary = 1'b1;
    step();
    int_boundary = 1'b0; mip = '0;
    chk("mei_trap", 64'(trap_do_update), 64'd1);
    chk("mei_mcause", trap_mcause, 64'h8000_0000_0000_000B);
    chk("mei_mepc", trap_mepc, 64'h3000);
    chk("mei_mtval", trap_mtval, 64'd0);
    step();
    chk("mei_redir", 64'(redirect_valid), 64'd1);
    chk("mei_rpc", redirect_pc, vec_exp);
    step();

    // Platform line: lowest set bit of 16+
    mie = 32'h0003_0000; mip = 32'h0003_0000; int_boundary = 1'b1; mtvec = 64'h100;
    step();
    int_boundary = 1'b0; mip = '0;
    chk("plat_mcause", trap_mcause, 64'h8000_0000_0000_0010);
    step(); step();

    // MRET
    mstatus = 64'h1880; mepc = 64'h2000; mie = '0; mip = '0; mret_valid = 1'b1;
    step();
    mret_valid = 1'b0;
    chk("mret_upd", 64'(xret_do_update), 64'd1);
    chk("mret_flush", 64'(flush), 64'd1);
    chk("mret_mstatus", xret_new_mstatus, 64'h1888);
    chk("mret_priv", 64'(xret_new_privilege_mode), 64'd3);
    chk("mret_notrap", 64'(trap_do_update), 64'd0);
    mstatus = 64'h1888;
    step();
    chk("mret_redir", 64'(redirect_valid), 64'd1);
    chk("mret_rpc", redirect_pc, 64'h2000);
    step();

    // MRET that unmasks a pending MTI
    mstatus = 64'h1880; mtvec = 64'h8000_0100; mie = 32'h80; mip = 32'h80; mret_valid = 1'b1;
    step();
    mret_valid = 1'b0;
    chk("xc_upd", 64'(xret_do_update), 64'd1);
    mstatus = 64'h1888;
    step();
    chk("xc_noredir", 64'(redirect_valid), 64'd0);
    step();
    mip = '0;
    chk("xc_trap", 64'(trap_do_update), 64'd1);
    chk("xc_completing", 64'(xret_completing), 64'd1);
    chk("xc_mcause", trap_mcause, 64'h8000_0000_0000_0007);
    chk("xc_mtval", trap_mtval, 64'd0);
    step();
    chk("xc_redir", 64'(redirect_valid), 64'd1);
    chk("xc_rpc", redirect_pc, 64'h8000_0100);
    chk("xc_comp_off", 64'(xret_completing), 64'd0);
    step();

    // Exception and MRET together
    mstatus = 64'h0; mie = '0;
    exc_valid = 1'b1; mret_valid = 1'b1; exc_cause = 4'd5; exc_pc = 64'h4000; exc_tval = 64'h11;
    step();
    exc_valid = 1'b0; mret_valid = 1'b0;
    chk("both_ready0", 64'(req_ready), 64'd0);
    chk("both_noxret0", 64'(xret_do_update), 64'd0);
    chk("both_mcause", trap_mcause, 64'd5);
    step();
    chk("both_ready1", 64'(req_ready), 64'd0);
    chk("both_noxret1", 64'(xret_do_update), 64'd0);
    step();
    chk("both_ready2", 64'(req_ready), 64'd1);
    chk("both_noxret2", 64'(xret_do_update), 64'd0);

    // Reset during REDIRECT
    exc_valid = 1'b1; exc_cause = 4'd1;
    step();
    exc_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rr_redir", 64'(redirect_valid), 64'd0);
    chk("rr_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;
    step();
    chk("rr_trap", 64'(trap_do_update), 64'd0);
    chk("rr_redir2", 64'(redirect_valid), 64'd0);
    chk("rr_flush", 64'(flush), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
